// File: rtl/systolic_array_pkg.sv
// Shared opcodes and default sizing for the systolic array and its PEs.
package systolic_array_pkg;

    localparam logic [2:0] OP_WS_FLOW  = 3'b000;
    localparam logic [2:0] OP_W_LOAD   = 3'b001;
    localparam logic [2:0] OP_OS_FLOW  = 3'b100;
    localparam logic [2:0] OP_OS_DRAIN = 3'b110;

    localparam int unsigned DEF_ARRAY_N      = 8;
    localparam int unsigned DEF_ARRAY_M      = 8;
    localparam int unsigned DEF_ACT_WIDTH    = 8;
    localparam int unsigned DEF_WGT_WIDTH    = 8;
    localparam int unsigned DEF_PE_OUT_WIDTH = 32;

endpackage

// File: rtl/pe.sv
// Single processing element: activation/weight pipeline registers plus a signed MAC
// that serves both output-stationary and weight-stationary dataflows.
module pe
    import systolic_array_pkg::*;
#(
    parameter int unsigned ACT_WIDTH    = DEF_ACT_WIDTH,
    parameter int unsigned WGT_WIDTH    = DEF_WGT_WIDTH,
    parameter int unsigned PE_OUT_WIDTH = DEF_PE_OUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              op_i,
    input  logic [ACT_WIDTH-1:0]    a_i,
    input  logic [WGT_WIDTH-1:0]    w_i,
    input  logic [PE_OUT_WIDTH-1:0] p_i,
    output logic [ACT_WIDTH-1:0]    a_o,
    output logic [WGT_WIDTH-1:0]    w_o,
    output logic [PE_OUT_WIDTH-1:0] out_o
);

    localparam int unsigned ProdWidth = ACT_WIDTH + WGT_WIDTH;

    logic [ACT_WIDTH-1:0]    a_q, a_d;
    logic [WGT_WIDTH-1:0]    w_q, w_d;
    logic [PE_OUT_WIDTH-1:0] out_q, out_d;

    logic [WGT_WIDTH-1:0]        mul_w;
    logic signed [ProdWidth-1:0] prod;
    logic [PE_OUT_WIDTH-1:0]     prod_ext;

    // OS multiplies the weight flowing in; WS multiplies the stationary weight.
    assign mul_w    = (op_i == OP_OS_FLOW) ? w_i : w_q;
    assign prod     = ProdWidth'($signed(a_i)) * ProdWidth'($signed(mul_w));
    assign prod_ext = PE_OUT_WIDTH'(prod);

    always_comb begin
        a_d   = a_q;
        w_d   = w_q;
        out_d = out_q;
        case (op_i)
            OP_OS_FLOW: begin
                a_d   = a_i;
                w_d   = w_i;
                out_d = out_q + prod_ext;
            end
            OP_OS_DRAIN: begin
                out_d = p_i;
            end
            OP_W_LOAD: begin
                a_d   = '0;
                w_d   = w_i;
                out_d = '0;
            end
            OP_WS_FLOW: begin
                a_d   = a_i;
                out_d = p_i + prod_ext;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            w_q   <= '0;
            out_q <= '0;
        end else begin
            a_q   <= a_d;
            w_q   <= w_d;
            out_q <= out_d;
        end
    end

    assign a_o   = a_q;
    assign w_o   = w_q;
    assign out_o = out_q;

endmodule

// File: rtl/systolic_array.sv
// ARRAY_N x ARRAY_M grid of PEs: activations flow right, weights and partial sums flow down,
// and the bottom row's accumulators are exposed combinationally.
module systolic_array
    import systolic_array_pkg::*;
#(
    parameter int unsigned ARRAY_N      = DEF_ARRAY_N,
    parameter int unsigned ARRAY_M      = DEF_ARRAY_M,
    parameter int unsigned ACT_WIDTH    = DEF_ACT_WIDTH,
    parameter int unsigned WGT_WIDTH    = DEF_WGT_WIDTH,
    parameter int unsigned PE_OUT_WIDTH = DEF_PE_OUT_WIDTH,
    localparam int unsigned IBUF_DATA_WIDTH = ARRAY_N * ACT_WIDTH,
    localparam int unsigned WBUF_DATA_WIDTH = ARRAY_M * WGT_WIDTH,
    localparam int unsigned OUT_DATA_WIDTH  = ARRAY_M * PE_OUT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IBUF_DATA_WIDTH-1:0] act_data_set_in,
    input  logic [WBUF_DATA_WIDTH-1:0] wgt_data_set_in,
    input  logic [2:0]                 operation_signal_in,
    output logic [OUT_DATA_WIDTH-1:0]  result_data_set_out
);

    logic [ACT_WIDTH-1:0]    a_grid [ARRAY_N][ARRAY_M];
    logic [WGT_WIDTH-1:0]    w_grid [ARRAY_N][ARRAY_M];
    logic [PE_OUT_WIDTH-1:0] p_grid [ARRAY_N][ARRAY_M];

    // Right-edge activations and bottom-edge weights fall off the array.
    logic [ARRAY_N*ACT_WIDTH-1:0] unused_a_edge;
    logic [ARRAY_M*WGT_WIDTH-1:0] unused_w_edge;

    for (genvar r = 0; r < ARRAY_N; r++) begin : g_row
        for (genvar c = 0; c < ARRAY_M; c++) begin : g_col
            logic [ACT_WIDTH-1:0]    a_in;
            logic [WGT_WIDTH-1:0]    w_in;
            logic [PE_OUT_WIDTH-1:0] p_in;

            if (c == 0) begin : g_a_edge
                assign a_in = act_data_set_in[r*ACT_WIDTH +: ACT_WIDTH];
            end else begin : g_a_int
                assign a_in = a_grid[r][c-1];
            end

            if (r == 0) begin : g_wp_edge
                assign w_in = wgt_data_set_in[c*WGT_WIDTH +: WGT_WIDTH];
                assign p_in = '0;
            end else begin : g_wp_int
                assign w_in = w_grid[r-1][c];
                assign p_in = p_grid[r-1][c];
            end

            pe #(
                .ACT_WIDTH   (ACT_WIDTH),
                .WGT_WIDTH   (WGT_WIDTH),
                .PE_OUT_WIDTH(PE_OUT_WIDTH)
            ) u_pe (
                .clk  (clk),
                .reset(reset),
                .op_i (operation_signal_in),
                .a_i  (a_in),
                .w_i  (w_in),
                .p_i  (p_in),
                .a_o  (a_grid[r][c]),
                .w_o  (w_grid[r][c]),
                .out_o(p_grid[r][c])
            );
        end
        assign unused_a_edge[r*ACT_WIDTH +: ACT_WIDTH] = a_grid[r][ARRAY_M-1];
    end

    for (genvar c = 0; c < ARRAY_M; c++) begin : g_out
        assign result_data_set_out[c*PE_OUT_WIDTH +: PE_OUT_WIDTH] = p_grid[ARRAY_N-1][c];
        assign unused_w_edge[c*WGT_WIDTH +: WGT_WIDTH]              = w_grid[ARRAY_N-1][c];
    end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: directed diagonal runs, a table of single-PE
// accumulations, a narrow instance for wraparound, and random matmuls against a matrix model.
module tb_systolic_array;
    import systolic_array_pkg::*;

    localparam int N  = 8;
    localparam int M  = 8;
    localparam int AW = 8;
    localparam int WW = 8;
    localparam int PW = 32;
    localparam logic [2:0] OpIdle = 3'b010;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*AW-1:0] act = '0;
    logic [M*WW-1:0] wgt = '0;
    logic [2:0]      op = OpIdle;
    logic [M*PW-1:0] res;

    logic [7:0]  wr_act = '0;
    logic [7:0]  wr_wgt = '0;
    logic [2:0]  wr_op = OpIdle;
    logic [15:0] wr_res;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    systolic_array #(
        .ARRAY_N(N), .ARRAY_M(M), .ACT_WIDTH(AW), .WGT_WIDTH(WW), .PE_OUT_WIDTH(PW)
    ) u_dut (
        .clk                (clk),
        .reset              (reset),
        .act_data_set_in    (act),
        .wgt_data_set_in    (wgt),
        .operation_signal_in(op),
        .result_data_set_out(res)
    );

    systolic_array #(
        .ARRAY_N(1), .ARRAY_M(1), .ACT_WIDTH(8), .WGT_WIDTH(8), .PE_OUT_WIDTH(16)
    ) u_wrap (
        .clk                (clk),
        .reset              (reset),
        .act_data_set_in    (wr_act),
        .wgt_data_set_in    (wr_wgt),
        .operation_signal_in(wr_op),
        .result_data_set_out(wr_res)
    );

    typedef struct {
        logic signed [7:0] a;
        logic signed [7:0] w;
        int                n;
        logic [31:0]       exp;
        string             name;
    } os_vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        op    = 3'($urandom);
        act   = {$urandom, $urandom};
        wgt   = {$urandom, $urandom};
        step();
        reset = 1'b0;
        op    = OpIdle;
        act   = '0;
        wgt   = '0;
    endtask

    // Lane k carries 1 during cycles k..k+7.
    function automatic logic [63:0] diag(input int t);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++)
            if (t >= k && t <= k + 7) v[k*8 +: 8] = 8'd1;
        return v;
    endfunction

    task automatic os_diag_compute(input int ncyc);
        op = OP_OS_FLOW;
        for (int t = 0; t < ncyc; t++) begin
            act = diag(t);
            wgt = diag(t);
            step();
        end
        act = '0;
        wgt = '0;
    endtask

    task automatic drain_all_eights(input string name);
        logic [255:0] exp;
        for (int c = 0; c < M; c++) exp[c*PW +: PW] = 32'd8;
        op = OP_OS_DRAIN;
        for (int d = 0; d < N; d++) begin
            check($sformatf("%s_drain%0d", name, d), res, exp);
            step();
        end
    endtask

    task automatic run_os_random(input int it);
        int kl;
        int ma[N][8];
        int mw[8][M];
        int s;
        logic [255:0] exp;
        kl = int'($urandom_range(1, 8));
        for (int r = 0; r < N; r++)
            for (int k = 0; k < 8; k++) ma[r][k] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < M; c++) mw[k][c] = int'($urandom_range(0, 255)) - 128;
        do_reset();
        op = OP_OS_FLOW;
        for (int t = 0; t < N + M + kl - 2; t++) begin
            act = '0;
            wgt = '0;
            for (int r = 0; r < N; r++)
                if (t - r >= 0 && t - r < kl) act[r*AW +: AW] = 8'(ma[r][t-r]);
            for (int c = 0; c < M; c++)
                if (t - c >= 0 && t - c < kl) wgt[c*WW +: WW] = 8'(mw[t-c][c]);
            step();
        end
        act = '0;
        wgt = '0;
        op  = OP_OS_DRAIN;
        for (int d = 0; d < N; d++) begin
            exp = '0;
            for (int c = 0; c < M; c++) begin
                s = 0;
                for (int k = 0; k < kl; k++) s += ma[N-1-d][k] * mw[k][c];
                exp[c*PW +: PW] = 32'(s);
            end
            check($sformatf("os_rand%0d_row%0d", it, N - 1 - d), res, exp);
            step();
        end
    endtask

    task automatic run_ws_random(input int it);
        localparam int V = 6;
        int mw[N][M];
        int mx[V][N];
        int s;
        int v;
        logic [255:0] exp;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++) mw[r][c] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < V; i++)
            for (int r = 0; r < N; r++) mx[i][r] = int'($urandom_range(0, 255)) - 128;
        do_reset();
        // Row r ends up holding the lane value presented on load cycle N-1-r.
        op = OP_W_LOAD;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < M; c++) wgt[c*WW +: WW] = 8'(mw[N-1-i][c]);
            step();
        end
        wgt = '0;
        op  = OP_WS_FLOW;
        for (int t = 0; t <= V + N + M - 2; t++) begin
            exp = '0;
            for (int c = 0; c < M; c++) begin
                v = t - N - c;
                if (v >= 0 && v < V) begin
                    s = 0;
                    for (int r = 0; r < N; r++) s += mx[v][r] * mw[r][c];
                    exp[c*PW +: PW] = 32'(s);
                end
            end
            check($sformatf("ws_rand%0d_t%0d", it, t), res, exp);
            act = '0;
            for (int r = 0; r < N; r++)
                if (t - r >= 0 && t - r < V) act[r*AW +: AW] = 8'(mx[t-r][r]);
            step();
        end
        act = '0;
    endtask

    initial begin
        os_vec_t tbl[6];
        logic [255:0] exp;

        tbl[0] = '{-8'sd2,   8'sd3,   4, 32'hFFFF_FFE8, "neg_x_pos"};
        tbl[1] = '{8'sd127,  8'sd127, 5, 32'd80645,     "max_pos"};
        tbl[2] = '{-8'sd128, -8'sd128, 2, 32'd32768,    "max_neg_sq"};
        tbl[3] = '{-8'sd128, 8'sd127, 3, 32'hFFFF_4180, "min_x_max"};
        tbl[4] = '{8'sd0,    8'sd55,  3, 32'd0,         "zero_act"};
        tbl[5] = '{-8'sd1,   -8'sd1,  7, 32'd7,         "neg_x_neg"};

        do_reset();
        check("reset_state", 256'(res), 256'd0);

        // Diagonal OS run: every PE sees eight 1*1 products.
        do_reset();
        os_compute_and_drain: begin
            os_diag_compute(23);
            drain_all_eights("os_diag");
        end

        // WS with unit weights and the same diagonal activations.
        do_reset();
        op  = OP_W_LOAD;
        wgt = 64'h0101_0101_0101_0101;
        for (int i = 0; i < 9; i++) step();
        wgt = '0;
        op  = OP_WS_FLOW;
        for (int t = 0; t < 16; t++) begin
            exp = '0;
            for (int c = 0; c < M; c++)
                if (t >= 8 + c && t <= 15 + c) exp[c*PW +: PW] = 32'd8;
            check($sformatf("ws_diag_t%0d", t), res, exp);
            act = diag(t);
            step();
        end
        act = '0;

        // Single-PE accumulation table, drained down from row 0.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            op  = OP_OS_FLOW;
            act = '0;
            wgt = '0;
            act[7:0] = tbl[i].a;
            wgt[7:0] = tbl[i].w;
            for (int k = 0; k < tbl[i].n; k++) step();
            act = '0;
            wgt = '0;
            op  = OP_OS_DRAIN;
            for (int k = 0; k < N - 1; k++) step();
            check($sformatf("tbl_%s", tbl[i].name), 256'(res), 256'(tbl[i].exp));
        end

        // Reset in the middle of an OS run, then a clean rerun.
        do_reset();
        os_diag_compute(12);
        exp = '0;
        for (int c = 0; c < M; c++)
            if (12 - (7 + c) > 0) exp[c*PW +: PW] = 32'(12 - (7 + c));
        check("mid_os_partial", res, exp);
        reset = 1'b1;
        op    = OP_OS_FLOW;
        act   = diag(12);
        wgt   = diag(12);
        step();
        reset = 1'b0;
        check("mid_os_reset", 256'(res), 256'd0);
        os_diag_compute(23);
        drain_all_eights("after_reset");

        // Idle opcode between compute and drain must hold everything.
        do_reset();
        os_diag_compute(23);
        op = OpIdle;
        for (int i = 0; i < 5; i++) begin
            act = {$urandom, $urandom};
            wgt = {$urandom, $urandom};
            step();
        end
        act = '0;
        wgt = '0;
        drain_all_eights("idle_hold");

        // Narrow accumulator wraps modulo 2^16.
        do_reset();
        wr_op  = OP_OS_FLOW;
        wr_act = 8'd127;
        wr_wgt = 8'd127;
        for (int i = 0; i < 5; i++) step();
        check("wrap_5", 256'(wr_res), 256'(16'd15109));
        for (int i = 0; i < 5; i++) step();
        check("wrap_10", 256'(wr_res), 256'(16'd30218));
        wr_op  = OpIdle;
        wr_act = '0;
        wr_wgt = '0;

        for (int it = 0; it < 3; it++) run_os_random(it);
        for (int it = 0; it < 3; it++) run_ws_random(it);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
